// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between CPU (port 0) and loader (port 1, may lock).
// Grant is combinational, read data returns 1 cycle after grant; an ungranted requester holds req (CPU sees cpu_stall).
module mem_port_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic              lock1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              cpu_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  logic             last_owner_q, last_owner_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0] lock_cnt_inc;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic             gnt0, gnt1;

  // A held lock only matters while the loader keeps requesting; otherwise fall back to round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset_i) begin
      if (locked_q && req1_i) begin
        gnt1 = 1'b1;
      end else if (req0_i && req1_i) begin
        if (last_owner_q) gnt0 = 1'b1;
        else              gnt1 = 1'b1;
      end else if (req0_i) begin
        gnt0 = 1'b1;
      end else if (req1_i) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign lock_cnt_inc = lock_cnt_q + CNT_W'(1);

  always_comb begin
    last_owner_d = last_owner_q;
    locked_d     = locked_q;
    lock_cnt_d   = lock_cnt_q;
    if (gnt0) last_owner_d = 1'b0;
    if (gnt1) last_owner_d = 1'b1;
    // Hitting the cap releases the lock; last_owner=1 then hands the next tie to the CPU.
    if (gnt1 && lock1_i) begin
      if (lock_cnt_inc == LOCK_MAX_C) begin
        locked_d   = 1'b0;
        lock_cnt_d = '0;
      end else begin
        locked_d   = 1'b1;
        lock_cnt_d = lock_cnt_inc;
      end
    end else if (gnt1 || !req1_i) begin
      locked_d   = 1'b0;
      lock_cnt_d = '0;
    end
    rvalid0_d = gnt0 & ~we0_i;
    rvalid1_d = gnt1 & ~we1_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_owner_q <= 1'b1;
      locked_q     <= 1'b0;
      lock_cnt_q   <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      locked_q     <= locked_d;
      lock_cnt_q   <= lock_cnt_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
    end
  end

  assign gnt0_o      = gnt0;
  assign gnt1_o      = gnt1;
  assign cpu_stall_o = req0_i & ~gnt0;
  assign mem_en_o    = gnt0 | gnt1;
  assign mem_we_o    = (gnt0 & we0_i) | (gnt1 & we1_i);
  assign mem_addr_o  = gnt0 ? addr0_i : (gnt1 ? addr1_i : '0);
  assign mem_wdata_o = gnt0 ? wdata0_i : (gnt1 ? wdata1_i : '0);
  assign rvalid0_o   = rvalid0_q;
  assign rvalid1_o   = rvalid1_q;
  assign rdata0_o    = rvalid0_q ? mem_rdata_i : '0;
  assign rdata1_o    = rvalid1_q ? mem_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model on the mem_* side.
module tb_mem_port_arbiter;

  logic       clk;
  logic       reset;
  logic       req0, req1, we0, we1, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, cpu_stall, mem_en, mem_we;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  bit   [7:0] mem [256];
  int         total = 0;
  int         bad   = 0;
  int         la;
  logic       exp1;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .lock1_i(lock1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata0_o(rdata0), .rdata1_o(rdata1), .cpu_stall_o(cpu_stall),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: preloaded during reset, synchronous read.
  always @(posedge clk) begin
    if (reset) begin
      mem[8'h10] <= 8'hA5;
      mem[8'h20] <= 8'h5A;
      mem_rdata  <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; lock1 = 1'b0;
    addr0 = 8'h01; addr1 = 8'h02; wdata0 = 8'h77; wdata1 = 8'h66;

    // Reset held two cycles with both requests up.
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("rst_gnt0_%0d", c), 32'(gnt0), 0);
      check($sformatf("rst_gnt1_%0d", c), 32'(gnt1), 0);
      check($sformatf("rst_mem_en_%0d", c), 32'(mem_en), 0);
      check($sformatf("rst_rvalid0_%0d", c), 32'(rvalid0), 0);
      check($sformatf("rst_rvalid1_%0d", c), 32'(rvalid1), 0);
    end
    reset = 1'b0;
    #1;
    check("post_rst_gnt0", 32'(gnt0), 1);
    check("post_rst_gnt1", 32'(gnt1), 0);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check("idle_rvalid0", 32'(rvalid0), 1);
    check("idle_mem_en", 32'(mem_en), 0);
    check("idle_mem_addr", 32'(mem_addr), 0);
    check("idle_mem_wdata", 32'(mem_wdata), 0);

    // Single CPU read.
    req0 = 1'b1; addr0 = 8'h10; we0 = 1'b0;
    #1;
    check("rd0_gnt0", 32'(gnt0), 1);
    check("rd0_mem_addr", 32'(mem_addr), 32'h10);
    check("rd0_mem_we", 32'(mem_we), 0);
    check("rd0_stall", 32'(cpu_stall), 0);
    tick();
    req0 = 1'b0;
    #1;
    check("rd0_rvalid0", 32'(rvalid0), 1);
    check("rd0_rdata0", 32'(rdata0), 32'hA5);
    check("rd0_rvalid1", 32'(rvalid1), 0);
    check("rd0_rdata1", 32'(rdata1), 0);

    // Single loader read, steered to port 1.
    req1 = 1'b1; addr1 = 8'h20; we1 = 1'b0;
    #1;
    check("rd1_gnt1", 32'(gnt1), 1);
    check("rd1_gnt0", 32'(gnt0), 0);
    check("rd1_mem_addr", 32'(mem_addr), 32'h20);
    tick();
    req1 = 1'b0;
    #1;
    check("rd1_rvalid1", 32'(rvalid1), 1);
    check("rd1_rdata1", 32'(rdata1), 32'h5A);
    check("rd1_rvalid0", 32'(rvalid0), 0);
    check("rd1_rdata0", 32'(rdata0), 0);

    // Contention: last owner is the loader, so grants go 0,1,0,1,0,1.
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h30; addr1 = 8'h31;
    for (int k = 1; k <= 6; k++) begin
      #1;
      check($sformatf("rr_gnt0_%0d", k), 32'(gnt0), 32'(k % 2));
      check($sformatf("rr_gnt1_%0d", k), 32'(gnt1), 32'(1 - k % 2));
      check($sformatf("rr_stall_%0d", k), 32'(cpu_stall), 32'(1 - k % 2));
      if (k > 1) begin
        check($sformatf("rr_rvalid0_%0d", k), 32'(rvalid0), 32'(1 - k % 2));
        check($sformatf("rr_rvalid1_%0d", k), 32'(rvalid1), 32'(k % 2));
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check("rr_last_rvalid1", 32'(rvalid1), 1);

    // CPU write so the loader wins the next tie.
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'hF0; wdata0 = 8'h33;
    #1;
    check("wr0_gnt0", 32'(gnt0), 1);
    check("wr0_mem_we", 32'(mem_we), 1);
    check("wr0_mem_wdata", 32'(mem_wdata), 32'h33);
    tick();
    check("wr0_no_rvalid", 32'(rvalid0), 0);

    // Locked loader burst with LOCK_MAX=4: 1,1,1,1,0,1,1,1,1.
    we0 = 1'b0; addr0 = 8'h10;
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1;
    la = 0;
    for (int c = 0; c < 9; c++) begin
      addr1 = 8'(la); wdata1 = 8'(8'hC0 + la);
      #1;
      exp1 = (c != 4);
      check($sformatf("lk_gnt1_%0d", c), 32'(gnt1), 32'(exp1));
      check($sformatf("lk_gnt0_%0d", c), 32'(gnt0), 32'(!exp1));
      if (exp1) begin
        check($sformatf("lk_addr_%0d", c), 32'(mem_addr), 32'(la));
        check($sformatf("lk_wdata_%0d", c), 32'(mem_wdata), 32'(8'hC0 + la));
      end
      tick();
      if (exp1) la++;
    end
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) check($sformatf("lk_mem_%0d", i), 32'(mem[i]), 32'(8'hC0 + i));
    check("wr0_mem_F0", 32'(mem[8'hF0]), 32'h33);

    // Lock dropped on the second loader grant; pending CPU takes the next cycle.
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1; addr1 = 8'h40; wdata1 = 8'h11;
    #1;
    check("ld_gnt1_a", 32'(gnt1), 1);
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10; addr1 = 8'h41; lock1 = 1'b0;
    #1;
    check("ld_gnt1_b", 32'(gnt1), 1);
    check("ld_gnt0_b", 32'(gnt0), 0);
    tick();
    #1;
    check("ld_gnt0_c", 32'(gnt0), 1);
    check("ld_gnt1_c", 32'(gnt1), 0);
    tick();
    req0 = 1'b0; req1 = 1'b0;

    // Reset in the cycle after a CPU read grant.
    req0 = 1'b1; addr0 = 8'h20;
    #1;
    check("mr_gnt0", 32'(gnt0), 1);
    tick();
    reset = 1'b1; req1 = 1'b1;
    #1;
    check("mr_rst_gnt0", 32'(gnt0), 0);
    check("mr_rst_gnt1", 32'(gnt1), 0);
    check("mr_rst_mem_en", 32'(mem_en), 0);
    check("mr_rvalid0_before", 32'(rvalid0), 1);
    tick();
    check("mr_rvalid0_after", 32'(rvalid0), 0);
    reset = 1'b0;
    #1;
    check("mr_owner_gnt0", 32'(gnt0), 1);
    check("mr_owner_gnt1", 32'(gnt1), 0);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check("mr_reissue_rvalid0", 32'(rvalid0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
